// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: ID/EX hazard sources in, per-stage stall/flush and status out.
// The pipeline holds the master side; hazard_ctrl holds the slave side.
interface hazard_ctrl_if;
  logic [4:0]  rs1_addr_id;
  logic [4:0]  rs2_addr_id;
  logic [4:0]  rd_addr_ex;
  logic [2:0]  ResultSrc_ex;
  logic        Reg_Write_ex;
  logic        pc_src_ex;
  logic        md_start_ex;
  logic        md_done;
  logic        stall_if;
  logic        stall_id;
  logic        stall_ex;
  logic        flush_if;
  logic        flush_id;
  logic        flush_ex;
  logic        md_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output rs1_addr_id, rs2_addr_id, rd_addr_ex, ResultSrc_ex, Reg_Write_ex,
           pc_src_ex, md_start_ex, md_done,
    input  stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex,
           md_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, rd_addr_ex, ResultSrc_ex, Reg_Write_ex,
           pc_src_ex, md_start_ex, md_done,
    output stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex,
           md_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, mul/div wait with timeout recovery.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int         MD_TIMEOUT = 64,
    parameter logic [2:0] LOAD_SRC   = 3'b001
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     hz,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        RECOVER = 2'd2
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MD_TIMEOUT - 1);

    state_e     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       timeout_set;
    logic       md_timeout_q;
    logic       load_use;
    logic       s_if, s_id, s_ex, f_if, f_id, f_ex;

    assign load_use = hz.Reg_Write_ex && (hz.ResultSrc_ex == LOAD_SRC) &&
                      (hz.rd_addr_ex != 5'd0) &&
                      ((hz.rd_addr_ex == hz.rs1_addr_id) || (hz.rd_addr_ex == hz.rs2_addr_id));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            md_timeout_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            md_timeout_q <= md_timeout_q | timeout_set;
        end
    end

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        s_if = 1'b0; s_id = 1'b0; s_ex = 1'b0;
        f_if = 1'b0; f_id = 1'b0; f_ex = 1'b0;
        case (state)
            RUN: begin
                // A starting mul/div owns the cycle; branch and load-use are not acted on.
                if (hz.md_start_ex) begin
                    state_nxt = MD_WAIT;
                    wait_nxt  = 8'd0;
                end else if (hz.pc_src_ex) begin
                    f_if = 1'b1;
                    f_id = 1'b1;
                end else if (load_use) begin
                    s_if = 1'b1;
                    f_id = 1'b1;
                end
            end
            MD_WAIT: begin
                if (hz.md_done) begin
                    state_nxt = RUN;
                end else begin
                    s_if = 1'b1;
                    s_id = 1'b1;
                    s_ex = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        timeout_set = 1'b1;
                        state_nxt   = RECOVER;
                    end else begin
                        wait_nxt = wait_cnt + 8'd1;
                    end
                end
            end
            RECOVER: begin
                f_if = 1'b1;
                f_id = 1'b1;
                f_ex = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (rst) begin
            s_if = 1'b0; s_id = 1'b0; s_ex = 1'b0;
            f_if = 1'b0; f_id = 1'b0; f_ex = 1'b0;
        end
    end

    assign hz.stall_if   = s_if;
    assign hz.stall_id   = s_id;
    assign hz.stall_ex   = s_ex;
    assign hz.flush_if   = f_if;
    assign hz.flush_id   = f_id;
    assign hz.flush_ex   = f_ex;
    assign hz.md_timeout = md_timeout_q;
    assign state_dbg     = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Counters count cycles the outputs are actually asserted, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (s_if && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (f_id && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = 32'd0;
    assign hz.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_TIMEOUT=8: load-use, branch, mul/div, timeout, reset.
module tb_hazard_ctrl;
  localparam logic [31:0] O_NONE  = 32'b000000;
  localparam logic [31:0] O_LU    = 32'b100010;
  localparam logic [31:0] O_BR    = 32'b000110;
  localparam logic [31:0] O_STALL = 32'b111000;
  localparam logic [31:0] O_REC   = 32'b000111;
  localparam logic [31:0] S_RUN = 32'd0, S_WAIT = 32'd1, S_REC = 32'd2;
`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_STALLS = 32'd7, EXP_FLUSHES = 32'd3;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0, EXP_FLUSHES = 32'd0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  logic [31:0] exp_q[$];
  int n_cmp, n_err;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MD_TIMEOUT(8), .LOAD_SRC(3'b001)) dut (
    .clk(clk), .rst(rst), .hz(hz), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {26'd0, hz.stall_if, hz.stall_id, hz.stall_ex, hz.flush_if, hz.flush_id, hz.flush_ex};
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  // drivers: inputs change at negedge, outputs settle 1 time unit later
  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [2:0] rsrc, input logic rw,
                       input logic pc, input logic mds, input logic mdd);
    @(negedge clk);
    rst = r;
    hz.rs1_addr_id = rs1; hz.rs2_addr_id = rs2; hz.rd_addr_ex = rd;
    hz.ResultSrc_ex = rsrc; hz.Reg_Write_ex = rw;
    hz.pc_src_ex = pc; hz.md_start_ex = mds; hz.md_done = mdd;
    #1;
  endtask

  task automatic idle(input logic r, input logic mds, input logic mdd);
    drive(r, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, mds, mdd);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    hz.rs1_addr_id = '0; hz.rs2_addr_id = '0; hz.rd_addr_ex = '0; hz.ResultSrc_ex = '0;
    hz.Reg_Write_ex = 1'b0; hz.pc_src_ex = 1'b0; hz.md_start_ex = 1'b0; hz.md_done = 1'b0;

    // reset gates a live load-use hazard
    drive(1'b1, 5'd0, 5'd5, 5'd5, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_outs_gated", outs(), O_NONE);
    idle(1'b0, 1'b0, 1'b0);
    check("rst_state", {30'd0, state_dbg}, S_RUN);
    check("rst_timeout", {31'd0, hz.md_timeout}, 32'd0);
    check("rst_stall_cnt", hz.stall_cnt, 32'd0);
    check("rst_flush_cnt", hz.flush_cnt, 32'd0);
    check("rst_outs", outs(), O_NONE);

    // load-use on rs2, then gone next cycle
    drive(1'b0, 5'd0, 5'd5, 5'd5, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rs2", outs(), O_LU);
    drive(1'b0, 5'd0, 5'd5, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_one_cycle", outs(), O_NONE);
    check("lu_state_run", {30'd0, state_dbg}, S_RUN);
    drive(1'b0, 5'd7, 5'd1, 5'd7, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rs1", outs(), O_LU);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rd_zero", outs(), O_NONE);
    drive(1'b0, 5'd9, 5'd9, 5'd9, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_no_regwrite", outs(), O_NONE);
    drive(1'b0, 5'd3, 5'd4, 5'd6, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_no_match", outs(), O_NONE);
    drive(1'b0, 5'd0, 5'd5, 5'd5, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
    check("branch_over_lu", outs(), O_BR);

    // mul/div start ignores branch and load-use, then 4 wait cycles and done
    drive(1'b0, 5'd0, 5'd5, 5'd5, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
    check("md_start_outs", outs(), O_NONE);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 1'b0, 1'b0);
      check("md_wait_outs", outs(), O_STALL);
      check("md_wait_state", {30'd0, state_dbg}, S_WAIT);
    end
    idle(1'b0, 1'b0, 1'b1);
    check("md_done_outs", outs(), O_NONE);
    idle(1'b0, 1'b0, 1'b1);
    check("md_done_state", {30'd0, state_dbg}, S_RUN);
    check("md_done_ignored_run", outs(), O_NONE);

    // performance counters: 3 load-use events and a 4-cycle mul/div after reset
    idle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd2, 5'd0, 5'd2, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      check("perf_lu", outs(), O_LU);
    end
    idle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b0);
    check("perf_stall_cnt", hz.stall_cnt, EXP_STALLS);
    check("perf_flush_cnt", hz.flush_cnt, EXP_FLUSHES);

    // timeout: 8 stall cycles, sticky error, one recover cycle, back to run
    idle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      idle(1'b0, 1'b0, 1'b0);
      check("to_wait_outs", outs(), O_STALL);
      check("to_no_err_yet", {31'd0, hz.md_timeout}, 32'd0);
    end
    idle(1'b0, 1'b0, 1'b1);
    check("to_recover_state", {30'd0, state_dbg}, S_REC);
    check("to_recover_outs", outs(), O_REC);
    check("to_err_set", {31'd0, hz.md_timeout}, 32'd1);
    idle(1'b0, 1'b0, 1'b0);
    check("to_back_run", {30'd0, state_dbg}, S_RUN);
    check("to_run_outs", outs(), O_NONE);
    idle(1'b0, 1'b0, 1'b0);
    check("to_sticky", {31'd0, hz.md_timeout}, 32'd1);

    // reset during the third wait cycle
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    check("rw_wait2_outs", outs(), O_STALL);
    idle(1'b1, 1'b0, 1'b0);
    check("rw_rst_outs", outs(), O_NONE);
    idle(1'b0, 1'b0, 1'b0);
    check("rw_state", {30'd0, state_dbg}, S_RUN);
    check("rw_outs", outs(), O_NONE);
    check("rw_timeout_clr", {31'd0, hz.md_timeout}, 32'd0);
    check("rw_stall_cnt", hz.stall_cnt, 32'd0);
    check("rw_flush_cnt", hz.flush_cnt, 32'd0);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
